neureka_normquant_stream: RTL and testbench

- Streaming normalisation/quantisation engine for NLANE accumulator lanes.
- Per lane: multiply, optional bias, rounding, arithmetic shift, optional ReLU, saturation to 8/16/32 bits.
- Fully pipelined (3 stages) with valid/ready handshake and backpressure.
- Sits between the accumulator bank and the streamer output path; successor of the fixed 4-lane, handshake-less normquant.

---
 rtl/neureka_normquant_stream_pkg.sv | 32 +++
 rtl/neureka_normquant_stream_if.sv | 34 +++
 rtl/neureka_normquant_stream_lane.sv | 116 +++++++++++
 rtl/neureka_normquant_stream.sv | 103 ++++++++++
 tb/tb_neureka_normquant_stream.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neureka_normquant_stream_pkg.sv
// Shared types and defaults for the streaming norm/quant engine.
package neureka_normquant_stream_pkg;

  localparam int NORMQUANT_SHIFT_SIZE = 6;
  localparam int NORMQUANT_OUT_SIZE   = 32;

  typedef enum logic [1:0] {
    NQS_Q8    = 2'd0,
    NQS_Q16   = 2'd1,
    NQS_Q32   = 2'd2,
    NQS_QPASS = 2'd3
  } nqs_qmode_e;

  typedef struct packed {
    nqs_qmode_e qmode;
    logic       norm_signed;
    logic       bias_en;
    logic       round_en;
    logic       relu_en;
  } ctrl_nqs_t;

  // Saturation width in bits; pass-through uses the full output word.
  function automatic int nqs_qbits(input nqs_qmode_e qmode, input int outw);
    case (qmode)
      NQS_Q8:  return 8;
      NQS_Q16: return 16;
      NQS_Q32: return 32;
      default: return outw;
    endcase
  endfunction

endpackage

// File: rtl/neureka_normquant_stream_if.sv
// Beat-level valid/ready bus between accumulator bank, norm/quant engine and streamer.
interface neureka_normquant_stream_if
  import neureka_normquant_stream_pkg::*;
#(
  parameter int NLANE = 4,
  parameter int ACC   = 32,
  parameter int NMS   = 16,
  parameter int SHW   = NORMQUANT_SHIFT_SIZE,
  parameter int OUTW  = NORMQUANT_OUT_SIZE
) ();

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [NLANE*ACC-1:0]  acc_i;
  logic [NLANE*NMS-1:0]  norm_mult_i;
  logic [NLANE*ACC-1:0]  bias_i;
  logic [NLANE*SHW-1:0]  shift_i;
  ctrl_nqs_t             ctrl_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [NLANE*OUTW-1:0] data_o;
  logic [NLANE-1:0]      sat_o;

  modport slave (
    input  in_valid_i, acc_i, norm_mult_i, bias_i, shift_i, ctrl_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, sat_o
  );

  modport master (
    output in_valid_i, acc_i, norm_mult_i, bias_i, shift_i, ctrl_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, sat_o
  );

endinterface

// File: rtl/neureka_normquant_stream_lane.sv
// One lane of the 3-stage norm/quant datapath; stage registers load only on their enable.
module neureka_normquant_stream_lane
  import neureka_normquant_stream_pkg::*;
#(
  parameter int ACC  = 32,
  parameter int NMS  = 16,
  parameter int SHW  = NORMQUANT_SHIFT_SIZE,
  parameter int OUTW = NORMQUANT_OUT_SIZE
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_en1,
  input  logic            i_en2,
  input  logic            i_en3,
  input  logic [ACC-1:0]  i_acc,
  input  logic [NMS-1:0]  i_mult,
  input  logic [ACC-1:0]  i_bias,
  input  logic [SHW-1:0]  i_shift,
  input  ctrl_nqs_t       i_ctrl,
  output logic [OUTW-1:0] o_data,
  output logic            o_sat
);

  localparam int PW = ACC + NMS + 1;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] ONE = 1;

  logic signed [PW-1:0] w_acc_x, w_mul_x, w_prod;
  logic [NMS:0]         w_mult_ext;
  logic signed [PW-1:0] r_prod;
  logic [ACC-1:0]       r_bias1;
  logic [SHW-1:0]       r_shift1;
  logic                 r_bias_en1, r_round1, r_relu1, r_relu2;
  nqs_qmode_e           r_qmode1, r_qmode2;
  logic signed [SW-1:0] w_bias_x, w_rnd, w_sum, w_shr, r_val2;
  logic signed [SW-1:0] w_hi, w_lo, w_clamp;
  logic                 w_sat;
  int                   w_q;
  logic                 w_unused_hi;

  assign w_mult_ext = {i_ctrl.norm_signed & i_mult[NMS-1], i_mult};
  assign w_acc_x    = {{(PW-ACC){i_acc[ACC-1]}}, i_acc};
  assign w_mul_x    = {{(PW-NMS-1){w_mult_ext[NMS]}}, w_mult_ext};
  assign w_prod     = w_acc_x * w_mul_x;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prod     <= '0;
      r_bias1    <= '0;
      r_shift1   <= '0;
      r_bias_en1 <= 1'b0;
      r_round1   <= 1'b0;
      r_relu1    <= 1'b0;
      r_qmode1   <= NQS_Q8;
    end else if (i_en1) begin
      r_prod     <= w_prod;
      r_bias1    <= i_bias;
      r_shift1   <= i_shift;
      r_bias_en1 <= i_ctrl.bias_en;
      r_round1   <= i_ctrl.round_en;
      r_relu1    <= i_ctrl.relu_en;
      r_qmode1   <= i_ctrl.qmode;
    end
  end

  // A zero shift never rounds, so 2^(shift-1) is only formed for shift > 0.
  assign w_bias_x = r_bias_en1 ? {{(SW-ACC){r_bias1[ACC-1]}}, r_bias1} : '0;
  assign w_rnd    = (r_round1 && (r_shift1 != '0)) ? (ONE << (r_shift1 - SHW'(1))) : '0;
  assign w_sum    = {r_prod[PW-1], r_prod} + w_bias_x + w_rnd;
  assign w_shr    = w_sum >>> r_shift1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_val2   <= '0;
      r_relu2  <= 1'b0;
      r_qmode2 <= NQS_Q8;
    end else if (i_en2) begin
      r_val2   <= w_shr;
      r_relu2  <= r_relu1;
      r_qmode2 <= r_qmode1;
    end
  end

  // Negatives under ReLU clamp to zero silently; only true range overflow flags.
  always_comb begin
    w_q     = nqs_qbits(r_qmode2, OUTW);
    w_hi    = (ONE << (w_q - 1)) - ONE;
    w_lo    = -(ONE << (w_q - 1));
    w_clamp = r_val2;
    w_sat   = 1'b0;
    if (r_relu2) begin
      w_hi = (ONE << w_q) - ONE;
      w_lo = '0;
    end
    if (r_val2 < w_lo) begin
      w_clamp = w_lo;
      w_sat   = !r_relu2;
    end else if (r_val2 > w_hi) begin
      w_clamp = w_hi;
      w_sat   = 1'b1;
    end
  end

  assign w_unused_hi = ^w_clamp[SW-1:OUTW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      o_data <= '0;
      o_sat  <= 1'b0;
    end else if (i_en3) begin
      o_data <= w_clamp[OUTW-1:0];
      o_sat  <= w_sat;
    end
  end

endmodule

// File: rtl/neureka_normquant_stream.sv
// NLANE-wide pipelined norm/quant engine with valid/ready flow control.
// Define NEUREKA_NORMQUANT_STATS_EN to build the saturation event counter.
module neureka_normquant_stream
  import neureka_normquant_stream_pkg::*;
#(
  parameter int NLANE = 4,
  parameter int ACC   = 32,
  parameter int NMS   = 16,
  parameter int SHW   = NORMQUANT_SHIFT_SIZE,
  parameter int OUTW  = NORMQUANT_OUT_SIZE,
  parameter int CNTW  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            test_mode_i,
  input  logic                            clear_i,
  neureka_normquant_stream_if.slave       s_bus,
  output logic [CNTW-1:0]                 sat_count_o
);

  logic                  r_v1, r_v2, r_v3;
  logic                  w_en1, w_en2, w_en3;
  logic                  w_accept, w_ld2, w_ld3;
  logic [NLANE*OUTW-1:0] w_data;
  logic [NLANE-1:0]      w_sat;
  logic                  w_unused_test_mode;

  assign w_unused_test_mode = test_mode_i;

  // A stage may take new data when its successor is empty or moving on.
  assign w_en3 = !r_v3 || s_bus.out_ready_i;
  assign w_en2 = !r_v2 || w_en3;
  assign w_en1 = !r_v1 || w_en2;

  assign s_bus.in_ready_o  = !rst_i && !clear_i && w_en1;
  assign w_accept          = s_bus.in_valid_i && s_bus.in_ready_o;
  assign w_ld2             = w_en2 && r_v1 && !clear_i;
  assign w_ld3             = w_en3 && r_v2 && !clear_i;
  assign s_bus.out_valid_o = r_v3;
  assign s_bus.data_o      = w_data;
  assign s_bus.sat_o       = w_sat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (clear_i) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_en1) r_v1 <= w_accept;
      if (w_en2) r_v2 <= r_v1;
      if (w_en3) r_v3 <= r_v2;
    end
  end

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    neureka_normquant_stream_lane #(
      .ACC  (ACC),
      .NMS  (NMS),
      .SHW  (SHW),
      .OUTW (OUTW)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_en1   (w_accept),
      .i_en2   (w_ld2),
      .i_en3   (w_ld3),
      .i_acc   (s_bus.acc_i[g*ACC +: ACC]),
      .i_mult  (s_bus.norm_mult_i[g*NMS +: NMS]),
      .i_bias  (s_bus.bias_i[g*ACC +: ACC]),
      .i_shift (s_bus.shift_i[g*SHW +: SHW]),
      .i_ctrl  (s_bus.ctrl_i),
      .o_data  (w_data[g*OUTW +: OUTW]),
      .o_sat   (w_sat[g])
    );
  end

`ifdef NEUREKA_NORMQUANT_STATS_EN
  logic [CNTW-1:0] r_sat_cnt;
  logic [CNTW:0]   w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_sat_cnt} + (CNTW+1)'($countones(w_sat));

  // Counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sat_cnt <= '0;
    end else if (clear_i) begin
      r_sat_cnt <= '0;
    end else if (r_v3 && s_bus.out_ready_i) begin
      r_sat_cnt <= w_cnt_sum[CNTW] ? '1 : w_cnt_sum[CNTW-1:0];
    end
  end

  assign sat_count_o = r_sat_cnt;
`else
  assign sat_count_o = '0;
`endif

endmodule

// File: tb/tb_neureka_normquant_stream.sv
// Directed bench for neureka_normquant_stream; stats checks build with NEUREKA_NORMQUANT_STATS_EN.
module tb_neureka_normquant_stream;
  import neureka_normquant_stream_pkg::*;

  localparam int NLANE = 4;
  localparam int ACC   = 32;
  localparam int NMS   = 16;
  localparam int SHW   = 6;
  localparam int OUTW  = 32;
  localparam int CNTW  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            test_mode = 1'b0;
  logic            clear = 1'b0;
  logic [CNTW-1:0] sat_count;

  int n_checks = 0;
  int n_errors = 0;

  int        sent, got, cyc, n_out;
  logic      seen_bp, stalled;
  logic [NLANE*OUTW-1:0] hold_data;
  logic [NLANE-1:0]      hold_sat;

  neureka_normquant_stream_if #(
    .NLANE(NLANE), .ACC(ACC), .NMS(NMS), .SHW(SHW), .OUTW(OUTW)
  ) u_bus ();

  neureka_normquant_stream #(
    .NLANE(NLANE), .ACC(ACC), .NMS(NMS), .SHW(SHW), .OUTW(OUTW), .CNTW(CNTW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .test_mode_i (test_mode),
    .clear_i     (clear),
    .s_bus       (u_bus),
    .sat_count_o (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  function automatic ctrl_nqs_t mk_ctrl(input nqs_qmode_e q, input logic ns, input logic be,
                                        input logic re, input logic rl);
    ctrl_nqs_t c;
    c.qmode = q; c.norm_signed = ns; c.bias_en = be; c.round_en = re; c.relu_en = rl;
    return c;
  endfunction

  task automatic set_lane(input int l, input logic [31:0] a, input logic [15:0] m,
                          input logic [31:0] b, input logic [5:0] s);
    u_bus.acc_i[l*ACC +: ACC]       = a;
    u_bus.norm_mult_i[l*NMS +: NMS] = m;
    u_bus.bias_i[l*ACC +: ACC]      = b;
    u_bus.shift_i[l*SHW +: SHW]     = s;
  endtask

  task automatic set_all(input logic [31:0] a, input logic [15:0] m,
                         input logic [31:0] b, input logic [5:0] s);
    for (int l = 0; l < NLANE; l++) set_lane(l, a, m, b, s);
  endtask

  // One beat into an idle pipeline; checks acceptance, 3-cycle latency, lanes and flags.
  task automatic run_single(input string tag, input logic [NLANE*OUTW-1:0] exp_d,
                            input logic [NLANE-1:0] exp_s);
    int lat;
    @(negedge clk);
    u_bus.out_ready_i = 1'b1;
    u_bus.in_valid_i  = 1'b1;
    #1;
    check_val({tag, " in_ready"}, 64'(u_bus.in_ready_o), 64'd1);
    @(posedge clk);
    #1 u_bus.in_valid_i = 1'b0;
    lat = 1;
    while (!u_bus.out_valid_o && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, " latency"}, 64'(lat), 64'd3);
    for (int l = 0; l < NLANE; l++)
      check_val($sformatf("%s data[%0d]", tag, l), 64'(u_bus.data_o[l*OUTW +: OUTW]),
                64'(exp_d[l*OUTW +: OUTW]));
    check_val({tag, " sat"}, 64'(u_bus.sat_o), 64'(exp_s));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NLANE*OUTW-1:0] rep(input logic [OUTW-1:0] d);
    return {NLANE{d}};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_bus.in_valid_i  = 1'b0;
    u_bus.out_ready_i = 1'b0;
    u_bus.ctrl_i      = mk_ctrl(NQS_Q32, 1'b0, 1'b0, 1'b0, 1'b0);
    set_all(32'd0, 16'd0, 32'd0, 6'd0);

    // Reset state
    #12;
    check_val("rst out_valid", 64'(u_bus.out_valid_o), 64'd0);
    check_val("rst in_ready", 64'(u_bus.in_ready_o), 64'd0);
    check_val("rst sat", 64'(u_bus.sat_o), 64'd0);
    check_val("rst sat_count", 64'(sat_count), 64'd0);
    for (int l = 0; l < NLANE; l++)
      check_val($sformatf("rst data[%0d]", l), 64'(u_bus.data_o[l*OUTW +: OUTW]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("post-rst in_ready", 64'(u_bus.in_ready_o), 64'd1);

    // 1000*3=3000, +2 round, >>>2 -> 750
    u_bus.ctrl_i = mk_ctrl(NQS_Q16, 1'b0, 1'b0, 1'b1, 1'b0);
    set_all(32'd1000, 16'd3, 32'd0, 6'd2);
    run_single("round_q16", rep(32'd750), 4'b0000);

    u_bus.ctrl_i = mk_ctrl(NQS_Q8, 1'b0, 1'b0, 1'b1, 1'b0);
    run_single("sat_q8", rep(32'd127), 4'b1111);

    u_bus.ctrl_i = mk_ctrl(NQS_Q8, 1'b0, 1'b0, 1'b1, 1'b1);
    run_single("relu_sat_q8", rep(32'd255), 4'b1111);

    set_all(-32'sd1000, 16'd3, 32'd0, 6'd2);
    run_single("relu_neg", rep(32'd0), 4'b0000);

    // -5+1 = -4 >>> 1 = -2 ; with bias 7: 3 >>> 1 = 1
    u_bus.ctrl_i = mk_ctrl(NQS_Q32, 1'b0, 1'b0, 1'b1, 1'b0);
    set_all(-32'sd5, 16'd1, 32'd7, 6'd1);
    run_single("neg_round", rep(32'hFFFF_FFFE), 4'b0000);
    u_bus.ctrl_i = mk_ctrl(NQS_Q32, 1'b0, 1'b1, 1'b1, 1'b0);
    run_single("bias_round", rep(32'd1), 4'b0000);

    // mult 0xFFFF: signed -1 -> -5 ; unsigned 65535*5 = 327675 -> Q16 clamp 32767
    u_bus.ctrl_i = mk_ctrl(NQS_Q32, 1'b1, 1'b0, 1'b0, 1'b0);
    set_all(32'd5, 16'hFFFF, 32'd0, 6'd0);
    run_single("norm_signed", rep(32'hFFFF_FFFB), 4'b0000);
    u_bus.ctrl_i = mk_ctrl(NQS_Q16, 1'b0, 1'b0, 1'b0, 1'b0);
    run_single("norm_unsigned", rep(32'd32767), 4'b1111);

    set_all(-32'sd100000, 16'd1, 32'd0, 6'd0);
    run_single("neg_sat_q16", rep(32'hFFFF_8000), 4'b1111);

    // 0x7FFFFFFF*2 overflows the pass-through word
    u_bus.ctrl_i = mk_ctrl(NQS_QPASS, 1'b0, 1'b0, 1'b0, 1'b0);
    set_all(32'h7FFF_FFFF, 16'd2, 32'd0, 6'd0);
    run_single("qpass_sat", rep(32'h7FFF_FFFF), 4'b1110 | 4'b0001);

    // Backpressure: 10 beats, out_ready low for cycles 4..8
    u_bus.ctrl_i = mk_ctrl(NQS_Q32, 1'b0, 1'b0, 1'b0, 1'b0);
    sent = 0; got = 0; cyc = 0; seen_bp = 1'b0; stalled = 1'b0;
    while (got < 10 && cyc < 100) begin
      @(negedge clk);
      u_bus.out_ready_i = !(cyc >= 4 && cyc < 9);
      u_bus.in_valid_i  = (sent < 10);
      for (int l = 0; l < NLANE; l++) set_lane(l, 32'(1000 * (sent + 1) + l), 16'd1, 32'd0, 6'd0);
      #1;
      if (u_bus.out_valid_o && !u_bus.out_ready_i) begin
        if (stalled) begin
          check_val("bp hold data", u_bus.data_o[63:0] ^ u_bus.data_o[127:64],
                    hold_data[63:0] ^ hold_data[127:64]);
          check_val("bp hold sat", 64'(u_bus.sat_o), 64'(hold_sat));
        end
        hold_data = u_bus.data_o;
        hold_sat  = u_bus.sat_o;
        stalled   = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (u_bus.out_valid_o && u_bus.out_ready_i) begin
        for (int l = 0; l < NLANE; l++)
          check_val($sformatf("bp beat%0d[%0d]", got, l), 64'(u_bus.data_o[l*OUTW +: OUTW]),
                    64'(1000 * (got + 1) + l));
        got++;
      end
      if (u_bus.in_valid_i && u_bus.in_ready_o) sent++;
      else if (u_bus.in_valid_i) seen_bp = 1'b1;
      cyc++;
    end
    check_val("bp beats received", 64'(got), 64'd10);
    check_val("bp in_ready dropped", 64'(seen_bp), 64'd1);
    @(negedge clk);
    u_bus.in_valid_i = 1'b0;

    // Clear with 3 beats in flight and a simultaneous input beat
    u_bus.out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_all(32'(11 * (k + 1)), 16'd1, 32'd0, 6'd0);
      u_bus.in_valid_i = 1'b1;
      #1;
      check_val($sformatf("clr fill in_ready %0d", k), 64'(u_bus.in_ready_o), 64'd1);
    end
    @(negedge clk);
    set_all(32'd999, 16'd1, 32'd0, 6'd0);
    clear = 1'b1;
    #1;
    check_val("clr in_ready", 64'(u_bus.in_ready_o), 64'd0);
    @(posedge clk);
    #1;
    check_val("clr out_valid", 64'(u_bus.out_valid_o), 64'd0);
    check_val("clr data held", 64'(u_bus.data_o[OUTW-1:0]), 64'd11);
    @(negedge clk);
    clear = 1'b0;
    u_bus.in_valid_i  = 1'b0;
    u_bus.out_ready_i = 1'b1;
    n_out = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (u_bus.out_valid_o) n_out++;
    end
    check_val("clr no output", 64'(n_out), 64'd0);
    set_all(32'd1234, 16'd1, 32'd0, 6'd0);
    run_single("after_clear", rep(32'd1234), 4'b0000);

`ifdef NEUREKA_NORMQUANT_STATS_EN
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_val("stats cleared", 64'(sat_count), 64'd0);
    u_bus.ctrl_i = mk_ctrl(NQS_Q8, 1'b0, 1'b0, 1'b1, 1'b0);
    set_lane(0, 32'd1000, 16'd3, 32'd0, 6'd2);
    set_lane(1, 32'd1000, 16'd3, 32'd0, 6'd2);
    set_lane(2, 32'd10, 16'd3, 32'd0, 6'd2);
    set_lane(3, 32'd10, 16'd3, 32'd0, 6'd2);
    for (int k = 0; k < 4; k++)
      run_single($sformatf("stats beat%0d", k), {32'd8, 32'd8, 32'd127, 32'd127}, 4'b0011);
    check_val("stats count 8", 64'(sat_count), 64'd8);
    set_all(32'd1000, 16'd3, 32'd0, 6'd2);
    @(negedge clk);
    u_bus.in_valid_i  = 1'b1;
    u_bus.out_ready_i = 1'b1;
    for (int c = 0; c < 16500; c++) @(negedge clk);
    u_bus.in_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) @(negedge clk);
    check_val("stats saturate", 64'(sat_count), 64'hFFFF);
`endif

    // Asynchronous reset in the middle of a stalled stream
    u_bus.ctrl_i = mk_ctrl(NQS_Q8, 1'b0, 1'b0, 1'b1, 1'b0);
    set_all(32'd1000, 16'd3, 32'd0, 6'd2);
    @(negedge clk);
    u_bus.in_valid_i  = 1'b1;
    u_bus.out_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) @(negedge clk);
    check_val("pre-rst out_valid", 64'(u_bus.out_valid_o), 64'd1);
    check_val("pre-rst sat", 64'(u_bus.sat_o), 64'hF);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("async rst out_valid", 64'(u_bus.out_valid_o), 64'd0);
    check_val("async rst in_ready", 64'(u_bus.in_ready_o), 64'd0);
    check_val("async rst sat", 64'(u_bus.sat_o), 64'd0);
    check_val("async rst sat_count", 64'(sat_count), 64'd0);
    check_val("async rst data", u_bus.data_o[63:0] | u_bus.data_o[127:64], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    u_bus.in_valid_i  = 1'b0;
    u_bus.out_ready_i = 1'b1;
    n_out = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (u_bus.out_valid_o) n_out++;
    end
    check_val("rst discards beats", 64'(n_out), 64'd0);
    u_bus.ctrl_i = mk_ctrl(NQS_Q32, 1'b0, 1'b0, 1'b0, 1'b0);
    set_all(32'd42, 16'd1, 32'd0, 6'd0);
    run_single("after_rst", rep(32'd42), 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
